rx_descramble_depad: RTL
========================

Name: rx_descramble_depad

Overview:
- Bit-serial back end of the 802.11a receive path; the receive-side counterpart of the tx chain's scramble/tail/pad insertion.
- Takes the decoded (still scrambled) DATA-field bit stream: SERVICE(16) + PSDU(n_bits) + TAIL(6) + PAD(n_pad).
- Recovers the scrambler seed from the first 7 SERVICE bits, descrambles the stream and emits only PSDU bits, with valid and done strobes.
- Sits after the Viterbi decoder, ahead of the byte packer.

Parameters:
- LEN_W, 12, width of the n_bits PSDU bit-count input (max 4095 bits).
- SVC_BITS, 16, SERVICE field length in bits.
- TAIL_BITS, 6, tail length in bits.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches n_bits and n_pad and arms a frame; honoured only when ready=1.
- n_bits  input  LEN_W  PSDU length in bits.
- n_pad  input  6  number of pad bits after the tail (0..47).
- data_in  input  1  scrambled serial bit.
- in_valid  input  1  data_in is valid this cycle; no backpressure.
- data_out  output  1  descrambled PSDU bit.
- out_valid  output  1  data_out valid.
- done  output  1  one-cycle pulse after the last pad bit is consumed.
- service_err  output  1  sticky per frame; set if any descrambled SERVICE bit 7..15 is 1.
- ready  output  1  high in IDLE.

Behaviour:
- Reset values: data_out=0, out_valid=0, done=0, service_err=0, ready=1, state=IDLE, scrambler state=0, counters=0.
- Scrambler: 7-bit state s[6:0]; keystream k = s[6]^s[3] (x^7+x^4+1).
- States: IDLE, SEED, SVC, DATA, TAIL, PAD, DONE.
- IDLE: ready=1. On start, latch n_bits and n_pad, clear service_err, clear the bit counter, go to SEED. Bits arriving in IDLE are ignored.
- SEED (SERVICE bits 0..6): the plain bits are zero by definition, so each valid bit shifts directly: s <= {s[5:0], data_in}. After 7 valid bits go to SVC.
- SVC (SERVICE bits 7..15): d = data_in^k; s <= {s[5:0], k}. If d=1, set service_err. After 9 valid bits go to DATA, or to TAIL if n_bits=0.
- DATA: d = data_in^k; scrambler advances as in SVC. data_out<=d and out_valid<=1 registered, so output lags the input bit by 1 cycle. After n_bits valid bits go to TAIL.
- TAIL: consume 6 valid bits; no output; scrambler still advances. Tail content is not checked. Then go to PAD, or to DONE if n_pad=0.
- PAD: consume n_pad valid bits; no output. Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ready returns to 1 the cycle after done.
- in_valid=0 in any state: counters and scrambler hold; out_valid=0 that cycle.
- start while ready=0: ignored. n_bits and n_pad changes after latching: ignored.
- reset asserted mid-frame: all outputs return to reset values next edge; the partial frame is discarded, and no done is emitted.
- Counter: one shared LEN_W-bit down-counter, reloaded on each state entry (7, 9, n_bits, 6, n_pad). No wrap: the transition happens when the counter hits 0 on a valid bit.

Decomposition:
- Shared package wlan_rx_pkg holds the state encoding (localparams IDLE..DONE), SVC_BITS, TAIL_BITS, SEED_BITS=7, and the scrambler tap positions, shared with tx.
- One natural sub-module: rx_scrambler_lfsr, a 7-bit LFSR with load-bit, advance and keystream outputs. It is reusable by the tx scrambler model in benches.

Test Plan:
- All-ones seed, PSDU of n_bits=24 zeros, n_pad=0: input = the scrambler sequence starting 0000111011110010... plus 6 zero tail bits -> 24 out_valid pulses with data_out=0, service_err=0, done 1 cycle after the last tail bit.
- Seed 1011101, n_bits=16, PSDU 0xA5C3 (LSB first), n_pad=10 -> output bits equal 0xA5C3 LSB-first; exactly 16 out_valid pulses; done after 16+16+6+10 valid inputs.
- Same frame with in_valid toggling 1,0,1,0 -> identical output sequence; out_valid never high on a cycle following an in_valid=0 cycle; total cycles doubled.
- SERVICE bit 9 flipped in the input -> service_err=1, held through done; PSDU still correct.
- n_bits=0, n_pad=0 -> no out_valid; done after exactly 22 valid bits.
- reset pulse after 10 PSDU bits, then a new start -> no done from the first frame; the second frame decodes correctly with service_err cleared.

Source files
------------

// File: rtl/wlan_rx_pkg.sv
// Definitions shared by the 802.11a rx descrambler/depadder and the tx scrambler models:
// FSM encoding, DATA-field section lengths and the x^7+x^4+1 scrambler taps.
package wlan_rx_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEED = 3'd1,
      SVC  = 3'd2,
      DATA = 3'd3,
      TAIL = 3'd4,
      PAD  = 3'd5,
      DONE = 3'd6
   } rx_state_t;

   localparam int SVC_BITS   = 16;
   localparam int TAIL_BITS  = 6;
   localparam int SEED_BITS  = 7;

   localparam int SCR_W      = 7;
   localparam int SCR_TAP_HI = 6;
   localparam int SCR_TAP_LO = 3;

   function automatic logic scr_key(input logic [SCR_W-1:0] s);
      return s[SCR_TAP_HI] ^ s[SCR_TAP_LO];
   endfunction

endpackage

// File: rtl/rx_descramble_depad_if.sv
// Frame control and serial bit stream between the Viterbi back end and the descrambler;
// master drives start/length/data, slave returns PSDU bits and frame status.
interface rx_descramble_depad_if #(
   parameter int LEN_W = 12
);
   logic             start;
   logic [LEN_W-1:0] n_bits;
   logic [5:0]       n_pad;
   logic             data_in;
   logic             in_valid;
   logic             data_out;
   logic             out_valid;
   logic             done;
   logic             service_err;
   logic             ready;

   modport master (
      output start, n_bits, n_pad, data_in, in_valid,
      input  data_out, out_valid, done, service_err, ready
   );

   modport slave (
      input  start, n_bits, n_pad, data_in, in_valid,
      output data_out, out_valid, done, service_err, ready
   );
endinterface

// File: rtl/rx_scrambler_lfsr.sv
// 7-bit x^7+x^4+1 scrambler state: load shifts a raw bit in (seed recovery),
// advance shifts the keystream bit in (free-running); load wins if both are set.
module rx_scrambler_lfsr
   import wlan_rx_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic advance,
   input  logic din,
   output logic keystream
);

   logic [SCR_W-1:0] s_q;

   assign keystream = scr_key(s_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q <= '0;
      end else if (load) begin
         s_q <= {s_q[SCR_W-2:0], din};
      end else if (advance) begin
         s_q <= {s_q[SCR_W-2:0], keystream};
      end
   end

endmodule

// File: rtl/rx_descramble_depad.sv
// Recovers the scrambler seed from SERVICE, descrambles and emits only PSDU bits one cycle
// after each valid input; tail and pad are swallowed. No backpressure: in_valid=0 simply stalls.
module rx_descramble_depad
   import wlan_rx_pkg::*;
#(
   parameter int LEN_W     = 12,
   parameter int SVC_BITS  = wlan_rx_pkg::SVC_BITS,
   parameter int TAIL_BITS = wlan_rx_pkg::TAIL_BITS
)(
   input  logic                  clk,
   input  logic                  reset,
   rx_descramble_depad_if.slave  bus
);

   rx_state_t        state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] n_bits_q;
   logic [5:0]       n_pad_q;
   logic             data_out_q;
   logic             out_valid_q;
   logic             service_err_q;

   logic             latch;
   logic             set_err;
   logic             scr_load;
   logic             scr_adv;
   logic             emit;
   logic             key;
   logic             plain;
   logic             last;

   rx_scrambler_lfsr u_lfsr (
      .clk       (clk),
      .reset     (reset),
      .load      (scr_load),
      .advance   (scr_adv),
      .din       (bus.data_in),
      .keystream (key)
   );

   assign plain = bus.data_in ^ key;
   assign last  = (cnt_q == '0);

   // The counter is loaded with (section length - 1) on entry, so a section ends on the
   // valid bit that finds it at zero; zero-length sections are skipped at the source.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch    = 1'b0;
      set_err  = 1'b0;
      scr_load = 1'b0;
      scr_adv  = 1'b0;
      emit     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               latch   = 1'b1;
               state_d = SEED;
               cnt_d   = LEN_W'(SEED_BITS - 1);
            end
         end

         SEED: begin
            if (bus.in_valid) begin
               scr_load = 1'b1;
               if (last) begin
                  state_d = SVC;
                  cnt_d   = LEN_W'(SVC_BITS - SEED_BITS - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         SVC: begin
            if (bus.in_valid) begin
               scr_adv = 1'b1;
               set_err = plain;
               if (last) begin
                  if (n_bits_q == '0) begin
                     state_d = TAIL;
                     cnt_d   = LEN_W'(TAIL_BITS - 1);
                  end else begin
                     state_d = DATA;
                     cnt_d   = n_bits_q - 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         DATA: begin
            if (bus.in_valid) begin
               scr_adv = 1'b1;
               emit    = 1'b1;
               if (last) begin
                  state_d = TAIL;
                  cnt_d   = LEN_W'(TAIL_BITS - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         TAIL: begin
            if (bus.in_valid) begin
               scr_adv = 1'b1;
               if (last) begin
                  if (n_pad_q == '0) begin
                     state_d = DONE;
                     cnt_d   = '0;
                  end else begin
                     state_d = PAD;
                     cnt_d   = LEN_W'(n_pad_q) - 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         PAD: begin
            if (bus.in_valid) begin
               if (last) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         n_bits_q      <= '0;
         n_pad_q       <= '0;
         data_out_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         service_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= emit;
         if (emit) begin
            data_out_q <= plain;
         end
         if (latch) begin
            n_bits_q      <= bus.n_bits;
            n_pad_q       <= bus.n_pad;
            service_err_q <= 1'b0;
         end else if (set_err) begin
            service_err_q <= 1'b1;
         end
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.service_err = service_err_q;
   assign bus.done        = (state_q == DONE);
   assign bus.ready       = (state_q == IDLE);

endmodule
